// File: rtl/gate_bist_pkg.sv
// Shared types and truth tables for the gate BIST sequencer.
package gate_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        DONE
    } bist_state_t;

    localparam int SETTLE_W = 4;

    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [1:0] TT_NOT1  = 2'b01;

endpackage

// File: rtl/gate_bist_timer.sv
// Loadable down-counter; expire flags the last wait cycle.
module gate_bist_timer
    import gate_bist_pkg::*;
#(
    parameter int W = SETTLE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign expire = (cnt == ONE);

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: walks every input vector through a gate and
// compares the settled output against an expected truth table.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int                    N_IN          = 2,
    parameter int                    SETTLE_CYCLES = 2,
    parameter logic [(1<<N_IN)-1:0]  EXPECT        = TT_OR2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] gate_in,
    input  logic            gate_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam logic [N_IN-1:0] VMAX    = '1;
    localparam logic [N_IN-1:0] VEC_ONE = 1;
    localparam logic [N_IN:0]   ERR_ONE = 1;

    bist_state_t     state, state_n;
    logic [N_IN-1:0] vec, vec_n;
    logic [N_IN-1:0] gate_in_n, ffv_n;
    logic [N_IN:0]   err_n;
    logic            busy_n, done_n, pass_n, fv_n;
    logic            t_load, t_exp, mism;

    gate_bist_timer #(.W(SETTLE_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (SETTLE_W'(SETTLE_CYCLES)),
        .expire   (t_exp)
    );

    // Case-inequality so an unknown gate output is a mismatch
    assign mism = (gate_out !== EXPECT[vec]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            vec            <= '0;
            gate_in        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            state          <= state_n;
            vec            <= vec_n;
            gate_in        <= gate_in_n;
            busy           <= busy_n;
            done           <= done_n;
            pass           <= pass_n;
            err_count      <= err_n;
            fail_valid     <= fv_n;
            first_fail_vec <= ffv_n;
        end
    end

    always_comb begin
        state_n   = state;
        vec_n     = vec;
        gate_in_n = gate_in;
        busy_n    = busy;
        done_n    = done;
        pass_n    = pass;
        err_n     = err_count;
        fv_n      = fail_valid;
        ffv_n     = first_fail_vec;
        t_load    = 1'b0;

        // Abort beats every in-run action, including the final check
        if (busy && abort) begin
            state_n   = IDLE;
            gate_in_n = '0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_n = APPLY;
                        vec_n   = '0;
                        busy_n  = 1'b1;
                        done_n  = 1'b0;
                        pass_n  = 1'b0;
                        err_n   = '0;
                        fv_n    = 1'b0;
                        ffv_n   = '0;
                    end
                end
                APPLY: begin
                    gate_in_n = vec;
                    t_load    = 1'b1;
                    state_n   = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                end
                SETTLE: begin
                    if (t_exp) state_n = CHECK;
                end
                CHECK: begin
                    if (mism) begin
                        err_n = err_count + ERR_ONE;
                        if (!fail_valid) begin
                            fv_n  = 1'b1;
                            ffv_n = vec;
                        end
                    end
                    if (vec == VMAX) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_n == '0);
                    end else begin
                        vec_n   = vec + VEC_ONE;
                        state_n = APPLY;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Randomised and directed checks of gate_bist_ctrl against a timeline model.
module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [3:0] mask = 4'b0000;
    logic [3:0] tt = TT_OR2;

    logic [1:0] gi_a, gi_b, ffv_a, ffv_b;
    logic [2:0] ec_a, ec_b;
    logic go_a, go_b, busy_a, busy_b, done_a, done_b;
    logic pass_a, pass_b, fv_a, fv_b;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Gate under test: the expected table with faulty rows flipped by mask
    assign go_a = tt[gi_a] ^ mask[gi_a];
    assign go_b = tt[gi_b] ^ mask[gi_b];

    gate_bist_ctrl #(.N_IN(2), .SETTLE_CYCLES(2), .EXPECT(TT_OR2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .gate_in(gi_a), .gate_out(go_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(ec_a), .fail_valid(fv_a),
        .first_fail_vec(ffv_a)
    );

    gate_bist_ctrl #(.N_IN(2), .SETTLE_CYCLES(0), .EXPECT(TT_OR2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .gate_in(gi_b), .gate_out(go_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(ec_b), .fail_valid(fv_b),
        .first_fail_vec(ffv_b)
    );

    function automatic void check(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Timeline model: each vector takes per = SETTLE+2 cycles after start;
    // vector v is applied at elapsed cycle v*per+1 and judged at (v+1)*per.
    int         per [2] = '{4, 2};
    int         m_t [2];
    logic       m_busy [2], m_done [2], m_pass [2], m_fv [2];
    logic [2:0] m_err [2];
    logic [1:0] m_ffv [2], m_gi [2];
    int         mv;
    logic       g_val;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_t[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_pass[k] = 0;
            m_fv[k] = 0; m_err[k] = 0; m_ffv[k] = 0; m_gi[k] = 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_t[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_pass[k] = 0;
                m_fv[k] = 0; m_err[k] = 0; m_ffv[k] = 0; m_gi[k] = 0;
            end else if (!m_busy[k]) begin
                if (start) begin
                    m_busy[k] = 1; m_t[k] = 0; m_done[k] = 0; m_pass[k] = 0;
                    m_err[k] = 0; m_fv[k] = 0; m_ffv[k] = 0;
                end
            end else if (abort) begin
                m_busy[k] = 0;
                m_gi[k] = 0;
            end else begin
                m_t[k]++;
                if ((m_t[k] - 1) % per[k] == 0)
                    m_gi[k] = 2'((m_t[k] - 1) / per[k]);
                if (m_t[k] % per[k] == 0) begin
                    mv = m_t[k] / per[k] - 1;
                    g_val = tt[mv] ^ mask[mv];
                    if (g_val != tt[mv]) begin
                        m_err[k]++;
                        if (!m_fv[k]) begin
                            m_fv[k] = 1;
                            m_ffv[k] = 2'(mv);
                        end
                    end
                    if (mv == 3) begin
                        m_busy[k] = 0;
                        m_done[k] = 1;
                        m_pass[k] = (m_err[k] == 0);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("a_busy", busy_a, m_busy[0]);
        check("a_done", done_a, m_done[0]);
        check("a_pass", pass_a, m_pass[0]);
        check("a_gate_in", gi_a, m_gi[0]);
        check("a_err_count", ec_a, m_err[0]);
        check("a_fail_valid", fv_a, m_fv[0]);
        if (m_fv[0]) check("a_first_fail", ffv_a, m_ffv[0]);
        check("b_busy", busy_b, m_busy[1]);
        check("b_done", done_b, m_done[1]);
        check("b_pass", pass_b, m_pass[1]);
        check("b_gate_in", gi_b, m_gi[1]);
        check("b_err_count", ec_b, m_err[1]);
        check("b_fail_valid", fv_b, m_fv[1]);
        if (m_fv[1]) check("b_first_fail", ffv_b, m_ffv[1]);
    end

    task automatic run_check(input int restart_at, output int la, output int lb);
        int n;
        la = -1;
        lb = -1;
        n = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy_a, 1);
        check("start_done", done_a, 0);
        check("start_err_clr", ec_a, 0);
        check("start_fv_clr", fv_a, 0);
        while (la < 0 && n < 40) begin
            if (n == restart_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n++;
            if (n <= 16 && n % 4 == 3) check("gate_in_seq", gi_a, (n - 1) / 4);
            if (done_b && lb < 0) lb = n;
            if (done_a) la = n;
        end
    endtask

    int la, lb;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_gate_in", gi_a, 0);
        check("rst_err", ec_a, 0);
        rst_n = 1'b1;

        // Healthy OR
        mask = 4'b0000;
        run_check(-1, la, lb);
        check("or_latency_a", la, 16);
        check("or_latency_b", lb, 8);
        check("or_pass", pass_a, 1);
        check("or_err", ec_a, 0);
        check("or_fv", fv_a, 0);
        check("or_pass_b", pass_b, 1);

        // Output stuck at 0
        mask = 4'b1110;
        run_check(-1, la, lb);
        check("sa0_latency", la, 16);
        check("sa0_pass", pass_a, 0);
        check("sa0_err", ec_a, 3);
        check("sa0_fv", fv_a, 1);
        check("sa0_ffv", ffv_a, 1);
        check("sa0_err_b", ec_b, 3);

        // AND gate judged against the OR table
        mask = TT_OR2 ^ TT_AND2;
        run_check(-1, la, lb);
        check("and_err", ec_a, 2);
        check("and_ffv", ffv_a, 1);
        check("and_pass", pass_a, 0);

        // Restart from DONE clears results; start while busy is ignored
        mask = 4'b0000;
        run_check(5, la, lb);
        check("restart_latency", la, 16);
        check("restart_err", ec_a, 0);
        check("restart_pass", pass_a, 1);

        // Abort mid-run
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy_a, 0);
        check("abort_gate_in", gi_a, 0);
        check("abort_done", done_a, 0);
        check("abort_busy_b", busy_b, 0);
        run_check(-1, la, lb);
        check("after_abort_latency", la, 16);
        check("after_abort_pass", pass_a, 1);

        // Asynchronous reset mid-run, between clock edges
        mask = 4'b0010;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy_a, 0);
        check("arst_gate_in", gi_a, 0);
        check("arst_err", ec_a, 0);
        check("arst_fv", fv_a, 0);
        check("arst_done", done_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            start = ($urandom % 12 == 0);
            abort = ($urandom % 40 == 0);
            if ($urandom % 30 == 0) mask = 4'($urandom);
            if ($urandom % 600 == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
